lut4_cfg_sequencer: RTL

Runtime configuration controller for a bank of NUM_LUTS programmable 4-input LUT cells. Each cell holds a 16-bit INIT truth table using the same bit ordering as our VMW_LUT4_xxxx macros: INIT bit index = {I3,I2,I1,I0}. A requester writes INIT words through a valid/ready port. The sequencer shifts each word serially (MSB first) into a shadow bank. A commit then swaps all shadow INITs into the active bank atomically. The active bank evaluates every cycle with a registered output, so the datapath never sees a partially loaded function.

---
 rtl/lut4_cfg_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/lut4_cfg_sequencer.sv
// Runtime configuration sequencer for a bank of 4-input LUT cells: serial shadow
// loading of 16-bit INIT words, atomic commit to the active bank, registered evaluation.
module lut4_cfg_sequencer #(
  parameter int NUM_LUTS = 8,
  parameter int IDX_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [15:0]           cfg_init,
  input  logic                  cfg_commit,
  output logic                  cfg_busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  input  logic [4*NUM_LUTS-1:0] eval_in,
  output logic [NUM_LUTS-1:0]   eval_out
);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  localparam logic [IDX_W:0] LUT_LIMIT = (IDX_W+1)'(NUM_LUTS);

  state_t             state, next_state;
  logic [15:0]        shadow [NUM_LUTS];
  logic [15:0]        active [NUM_LUTS];
  logic [15:0]        sr;
  logic [3:0]         bit_cnt;
  logic [IDX_W-1:0]   load_idx;
  logic               idx_ok;
  logic               wr_fire;

  assign idx_ok  = ({1'b0, cfg_idx} < LUT_LIMIT);
  assign wr_fire = cfg_valid & cfg_ready;

  // Commit wins over a simultaneous write; this is the only input-to-output path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    next_state = state;
    cfg_ready  = (state == IDLE) && !cfg_commit;
    unique case (state)
      IDLE: begin
        if (cfg_commit)
          next_state = COMMIT;
        else if (cfg_valid && idx_ok)
          next_state = LOAD;
      end
      LOAD: begin
        if (bit_cnt == 4'd15)
          next_state = IDLE;
      end
      COMMIT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (!rst_n) begin
      state    <= IDLE;
      cfg_busy <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      state    <= next_state;
      cfg_busy <= (next_state != IDLE);
      cfg_done <= (state == COMMIT);
      cfg_err  <= wr_fire && !idx_ok;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr       <= '0;
      bit_cnt  <= '0;
      load_idx <= '0;
      eval_out <= '0;
      // NOTE: the INIT banks are small register arrays that must power up as constant-0
      // functions, so they are reset explicitly rather than left to an uninitialised RAM.
      for (int k = 0; k < NUM_LUTS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
    end else begin
      if (wr_fire && idx_ok) begin
        load_idx <= cfg_idx;
        sr       <= cfg_init;
        bit_cnt  <= '0;
      end

      if (state == LOAD) begin
        sr      <= {sr[14:0], 1'b0};
        bit_cnt <= bit_cnt + 4'd1;
        for (int k = 0; k < NUM_LUTS; k++) begin
          if (load_idx == IDX_W'(k))
            shadow[k] <= {shadow[k][14:0], sr[15]};
        end
      end

      // Shadow is copied whole so the datapath never sees a partially loaded bank.
      if (state == COMMIT) begin
        for (int k = 0; k < NUM_LUTS; k++)
          active[k] <= shadow[k];
      end

      for (int k = 0; k < NUM_LUTS; k++)
        eval_out[k] <= active[k][eval_in[4*k +: 4]];
    end
  end

endmodule
